// File: rtl/peak_tracker_pkg.sv
// Shared types and constants for the signed peak tracker.
package peak_tracker_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned SUM_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 8;

    // Signed saturation limits for the default accumulator width
    localparam logic [SUM_W_DEF-1:0] SUM_MAX_DEF = {1'b0, {(SUM_W_DEF-1){1'b1}}};
    localparam logic [SUM_W_DEF-1:0] SUM_MIN_DEF = {1'b1, {(SUM_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

endpackage

// File: rtl/signed_peak_tracker_sat_accum.sv
// Signed saturating adder: SUM_W + 1 bit sum, clamped to the signed range.
module sat_accum #(
    parameter int unsigned SUM_W = 16
) (
    input  logic [SUM_W-1:0] acc_i,
    input  logic [SUM_W-1:0] add_i,
    output logic [SUM_W-1:0] sum_c_o,
    output logic             ovf_c_o
);

    localparam logic [SUM_W-1:0] MAX_V = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] MIN_V = {1'b1, {(SUM_W-1){1'b0}}};

    logic [SUM_W:0] wide_c;

    // Widen by one sign bit; the top two bits disagree exactly on overflow
    always_comb begin
        wide_c  = {acc_i[SUM_W-1], acc_i} + {add_i[SUM_W-1], add_i};
        sum_c_o = wide_c[SUM_W-1:0];
        ovf_c_o = 1'b0;
        if (wide_c[SUM_W] != wide_c[SUM_W-1]) begin
            ovf_c_o = 1'b1;
            sum_c_o = wide_c[SUM_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/signed_peak_tracker.sv
// Running min/max/saturating sum/count over qualified signed samples.
// Optional: define PEAK_TRACKER_XCROSS_EN to build zero_cross detection.
module signed_peak_tracker
    import peak_tracker_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    input  logic             freeze,
    output logic [WIDTH-1:0] min_q,
    output logic [WIDTH-1:0] max_q,
    output logic [SUM_W-1:0] sum_q,
    output logic [CNT_W-1:0] cnt_q,
    output logic             empty,
    output logic             sum_ovf,
    output logic             zero_cross
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] min_d, max_d;
    logic [SUM_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_d;
    logic             empty_d, sum_ovf_d;
    logic [SUM_W-1:0] sample_ext_c;
    logic [SUM_W-1:0] acc_sum_c;
    logic             acc_ovf_c;

`ifdef PEAK_TRACKER_XCROSS_EN
    logic sign_q, sign_d;
    logic zero_cross_d;
`endif

    assign sample_ext_c = {{(SUM_W-WIDTH){in_data[WIDTH-1]}}, in_data};

    sat_accum #(.SUM_W(SUM_W)) u_sat_accum (
        .acc_i   (sum_q),
        .add_i   (sample_ext_c),
        .sum_c_o (acc_sum_c),
        .ovf_c_o (acc_ovf_c)
    );

    // Next-state and statistics update; clear beats freeze beats in_valid
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        empty_d   = empty;
        sum_ovf_d = sum_ovf;
`ifdef PEAK_TRACKER_XCROSS_EN
        sign_d       = sign_q;
        zero_cross_d = 1'b0;
`endif
        if (clear) begin
            state_d   = ST_EMPTY;
            min_d     = '0;
            max_d     = '0;
            sum_d     = '0;
            cnt_d     = '0;
            empty_d   = 1'b1;
            sum_ovf_d = 1'b0;
`ifdef PEAK_TRACKER_XCROSS_EN
            sign_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (freeze) begin
                        state_d = ST_FROZEN;
                    end else if (in_valid) begin
                        state_d = ST_TRACK;
                        min_d   = in_data;
                        max_d   = in_data;
                        sum_d   = sample_ext_c;
                        cnt_d   = CNT_W'(1);
                        empty_d = 1'b0;
`ifdef PEAK_TRACKER_XCROSS_EN
                        sign_d  = in_data[WIDTH-1];
`endif
                    end
                end
                ST_TRACK: begin
                    if (freeze) begin
                        state_d = ST_FROZEN;
                    end else if (in_valid) begin
                        if ($signed(in_data) < $signed(min_q)) min_d = in_data;
                        if ($signed(in_data) > $signed(max_q)) max_d = in_data;
                        sum_d     = acc_sum_c;
                        sum_ovf_d = sum_ovf | acc_ovf_c;
                        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
`ifdef PEAK_TRACKER_XCROSS_EN
                        zero_cross_d = in_data[WIDTH-1] ^ sign_q;
                        sign_d       = in_data[WIDTH-1];
`endif
                    end
                end
                ST_FROZEN: begin
                    if (!freeze) state_d = empty ? ST_EMPTY : ST_TRACK;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            empty   <= 1'b1;
            sum_ovf <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            empty   <= empty_d;
            sum_ovf <= sum_ovf_d;
        end
    end

`ifdef PEAK_TRACKER_XCROSS_EN
    // Previous-sign register and registered crossing pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q     <= 1'b0;
            zero_cross <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            zero_cross <= zero_cross_d;
        end
    end
`else
    assign zero_cross = 1'b0;
`endif

endmodule

// File: tb/tb_signed_peak_tracker.sv
// Directed self-checking bench for signed_peak_tracker (default parameters).
module tb_signed_peak_tracker;

    import peak_tracker_pkg::*;

`ifdef PEAK_TRACKER_XCROSS_EN
    localparam int XC_EN = 1;
`else
    localparam int XC_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        clear = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  min_q, max_q;
    logic [15:0] sum_q;
    logic [7:0]  cnt_q;
    logic        empty, sum_ovf, zero_cross;

    int n_cmp = 0;
    int n_bad = 0;

    signed_peak_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear      (clear),
        .freeze     (freeze),
        .min_q      (min_q),
        .max_q      (max_q),
        .sum_q      (sum_q),
        .cnt_q      (cnt_q),
        .empty      (empty),
        .sum_ovf    (sum_ovf),
        .zero_cross (zero_cross)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 ns after the edge
    task automatic step(input logic v, input int d, input logic c, input logic f);
        in_valid = v;
        in_data  = 8'(d);
        clear    = c;
        freeze   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input int mn, input int mx,
                               input int sm, input int cn, input int em, input int ov);
        check({tag, ".min"},   int'($signed(min_q)), mn);
        check({tag, ".max"},   int'($signed(max_q)), mx);
        check({tag, ".sum"},   int'($signed(sum_q)), sm);
        check({tag, ".cnt"},   int'(cnt_q),          cn);
        check({tag, ".empty"}, int'(empty),          em);
        check({tag, ".ovf"},   int'(sum_ovf),        ov);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_stats("rst", 0, 0, 0, 0, 1, 0);
        check("rst.zc", int'(zero_cross), 0);
        rst = 1'b1;

        // Ascending positive run, no sign change
        step(1'b1, 53, 1'b0, 1'b0);
        check("asc1.zc", int'(zero_cross), 0);
        check_stats("asc1", 53, 53, 53, 1, 0, 0);
        step(1'b1, 54, 1'b0, 1'b0);
        check("asc2.zc", int'(zero_cross), 0);
        step(1'b1, 55, 1'b0, 1'b0);
        check("asc3.zc", int'(zero_cross), 0);
        check_stats("asc", 53, 55, 162, 3, 0, 0);

        // Sign change -17 -> 37
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, -17, 1'b0, 1'b0);
        check("xc1.zc", int'(zero_cross), 0);
        step(1'b1, 37, 1'b0, 1'b0);
        check("xc2.zc", int'(zero_cross), XC_EN);
        check_stats("xc", -17, 37, 20, 2, 0, 0);
        step(1'b0, 0, 1'b0, 1'b0);
        check("xc3.zc", int'(zero_cross), 0);

        // Positive saturation with 127 x 300
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, 127, 1'b0, 1'b0);
            if (i == 255) check("psat255.cnt", int'(cnt_q), 255);
            if (i == 256) check("psat256.cnt", int'(cnt_q), 255);
            if (i == 258) begin
                check("psat258.sum", int'($signed(sum_q)), 32766);
                check("psat258.ovf", int'(sum_ovf), 0);
            end
            if (i == 259) begin
                check("psat259.sum", int'($signed(sum_q)), 32767);
                check("psat259.ovf", int'(sum_ovf), 1);
            end
        end
        check_stats("psat", 127, 127, 32767, 255, 0, 1);

        // Negative saturation with -128 x 257
        step(1'b0, 0, 1'b1, 1'b0);
        check("nclr.ovf", int'(sum_ovf), 0);
        for (int i = 1; i <= 257; i++) begin
            step(1'b1, -128, 1'b0, 1'b0);
            if (i == 256) begin
                check("nsat256.sum", int'($signed(sum_q)), -32768);
                check("nsat256.ovf", int'(sum_ovf), 0);
            end
        end
        check_stats("nsat", -128, -128, -32768, 255, 0, 1);

        // Freeze drops a sample; resend after unfreeze
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, -47, 1'b0, 1'b0);
        step(1'b1, -43, 1'b0, 1'b1);
        check_stats("frz", -47, -47, -47, 1, 0, 0);
        step(1'b1, -43, 1'b0, 1'b0);
        check("unfrz.cnt", int'(cnt_q), 1);
        step(1'b1, -43, 1'b0, 1'b0);
        check_stats("resend", -47, -43, -90, 2, 0, 0);
        check("resend.zc", int'(zero_cross), 0);

        // Clear wins over a same-cycle sample
        step(1'b1, 29, 1'b1, 1'b0);
        check_stats("clr", 0, 0, 0, 0, 1, 0);
        check("clr.zc", int'(zero_cross), 0);

        // Freeze from empty, then the next sample is a first sample
        step(1'b1, 10, 1'b0, 1'b1);
        check_stats("efrz", 0, 0, 0, 0, 1, 0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 10, 1'b0, 1'b0);
        check_stats("efirst", 10, 10, 10, 1, 0, 0);
        step(1'b1, -3, 1'b0, 1'b0);
        check("efirst.zc", int'(zero_cross), XC_EN);

        // Asynchronous reset between edges mid-stream
        step(1'b1, 20, 1'b0, 1'b0);
        step(1'b1, 30, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_stats("arst", 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, -8, 1'b0, 1'b0);
        check_stats("post", -8, -8, -8, 1, 0, 0);
        check("post.zc", int'(zero_cross), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
